// File: rtl/matvec_stream_mac_if.sv
// Valid/ready stream bundle with an end-of-frame marker.
// Carries the x input stream and the y output stream of matvec_stream_mac.
interface matvec_stream_mac_if #(
    parameter int W = 8
);
    logic                valid;
    logic                ready;
    logic                last;
    logic signed [W-1:0] data;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/matvec_stream_mac.sv
// Streaming y = K*x: x arrives one column per beat, y leaves one row per beat.
// Optional MATVEC_STREAM_LAST_CHECK_EN adds a sticky frame_err flag for s_last misplacement.
module matvec_stream_mac #(
    parameter int R   = 8,
    parameter int C   = 8,
    parameter int W_X = 8,
    parameter int W_K = 8
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [R-1:0][C-1:0][W_K-1:0] k,
    matvec_stream_mac_if.slave           s_if,
    matvec_stream_mac_if.master          m_if
`ifdef MATVEC_STREAM_LAST_CHECK_EN
    ,
    output logic                         frame_err
`endif
);
    localparam int W_Y = W_X + W_K + $clog2(C);
    localparam int W_P = W_X + W_K;
    localparam int CW  = (C > 1) ? $clog2(C) : 1;
    localparam int RW  = (R > 1) ? $clog2(R) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(C - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(R - 1);

    typedef enum logic {ACC, OUT} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         col_q, col_d;
    logic [RW-1:0]         row_q, row_d;
    logic signed [W_Y-1:0] acc_q [R];
    logic signed [W_Y-1:0] acc_d [R];
    logic signed [W_P-1:0] prod  [R];
    logic signed [W_Y-1:0] prod_ext [R];

    always_comb begin
        for (int r = 0; r < R; r++) begin
            prod[r]     = $signed(k[r][col_q]) * s_if.data;
            prod_ext[r] = {{(W_Y - W_P){prod[r][W_P-1]}}, prod[r]};
        end
    end

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        acc_d       = acc_q;
        s_if.ready  = 1'b0;
        m_if.valid  = 1'b0;
        m_if.last   = 1'b0;
        m_if.data   = '0;
        case (state_q)
            ACC: begin
                s_if.ready = 1'b1;
                if (s_if.valid) begin
                    // column 0 overwrites, so no separate clear cycle between frames
                    for (int r = 0; r < R; r++)
                        acc_d[r] = (col_q == '0) ? prod_ext[r] : acc_q[r] + prod_ext[r];
                    if (col_q == COL_LAST) begin
                        col_d   = '0;
                        row_d   = '0;
                        state_d = OUT;
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            OUT: begin
                m_if.valid = 1'b1;
                m_if.data  = acc_q[row_q];
                m_if.last  = (row_q == ROW_LAST);
                if (m_if.ready) begin
                    if (row_q == ROW_LAST) begin
                        row_d   = '0;
                        state_d = ACC;
                    end else begin
                        row_d = row_q + RW'(1);
                    end
                end
            end
            default: state_d = ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ACC;
            col_q   <= '0;
            row_q   <= '0;
            for (int r = 0; r < R; r++) acc_q[r] <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            acc_q   <= acc_d;
        end
    end

`ifdef MATVEC_STREAM_LAST_CHECK_EN
    logic frame_err_q;

    always_ff @(posedge clk) begin
        if (!rstn)
            frame_err_q <= 1'b0;
        else if (state_q == ACC && s_if.valid && (s_if.last != (col_q == COL_LAST)))
            frame_err_q <= 1'b1;
    end

    assign frame_err = frame_err_q;
`else
    logic unused_s_last;
    assign unused_s_last = s_if.last;
`endif
endmodule

// File: tb/tb_matvec_stream_mac.sv
// Directed, table-driven bench for matvec_stream_mac at default parameters.
// Adapts to MATVEC_STREAM_LAST_CHECK_EN being defined or not.
module tb_matvec_stream_mac;
    localparam int R   = 8;
    localparam int C   = 8;
    localparam int W_X = 8;
    localparam int W_K = 8;
    localparam int W_Y = 19;

    typedef logic [R-1:0][C-1:0][W_K-1:0] kmat_t;

    typedef struct {
        int kmode;      // 0: every element = kval, 1: identity
        int kval;
        int x[C];
        int y[R];
        bit gaps;
        int stall_row;
    } vec_t;

    logic  clk = 1'b0;
    logic  rstn;
    kmat_t k;
    int    tests = 0;
    int    fails = 0;
    vec_t  vecs[7];

    always #5 clk = ~clk;

    matvec_stream_mac_if #(.W(W_X)) s_if ();
    matvec_stream_mac_if #(.W(W_Y)) m_if ();

`ifdef MATVEC_STREAM_LAST_CHECK_EN
    logic frame_err;
`endif

    matvec_stream_mac #(.R(R), .C(C), .W_X(W_X), .W_K(W_K)) dut (
        .clk  (clk),
        .rstn (rstn),
        .k    (k),
        .s_if (s_if),
        .m_if (m_if)
`ifdef MATVEC_STREAM_LAST_CHECK_EN
        ,
        .frame_err (frame_err)
`endif
    );

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic kmat_t build_k(input int mode, input int val);
        kmat_t       m;
        logic [31:0] v;
        v = val;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                m[r][c] = (mode == 1) ? ((r == c) ? 8'd1 : 8'd0) : v[7:0];
        return m;
    endfunction

    // Ends at the negedge right after the last accepted beat.
    task automatic send_frame(input int x[C], input bit gaps, input int err_beat);
        int          i = 0;
        int          cyc = 0;
        bit          v;
        bit          rdy;
        logic [31:0] xv;
        while (i < C && cyc < 400) begin
            @(negedge clk);
            cyc++;
            v  = !gaps || ($urandom_range(0, 1) == 1);
            xv = x[i];
            s_if.valid = v;
            s_if.data  = xv[7:0];
            s_if.last  = (err_beat >= 0) ? (i == err_beat) : (i == C - 1);
            rdy = s_if.ready;
            chk("s_ready_in_acc", int'(rdy), 1);
            @(posedge clk);
            if (v && rdy) begin
`ifdef MATVEC_STREAM_LAST_CHECK_EN
                if (err_beat >= 0 && i == err_beat) begin
                    #1 chk("frame_err_set", int'(frame_err), 1);
                end
`endif
                i++;
            end
        end
        if (i < C) chk("send_timeout_beats", i, C);
        @(negedge clk);
        s_if.valid = 1'b0;
        s_if.last  = 1'b0;
        chk("latency_m_valid", int'(m_if.valid), 1);
    endtask

    // Starts at the negedge where row 0 must already be presented.
    task automatic recv_frame(input int y[R], input int stall_row);
        for (int j = 0; j < R; j++) begin
            if (j > 0) @(negedge clk);
            chk("m_valid", int'(m_if.valid), 1);
            chk("m_data", int'($signed(m_if.data)), y[j]);
            chk("m_last", int'(m_if.last), (j == R - 1) ? 1 : 0);
            chk("s_ready_in_out", int'(s_if.ready), 0);
            if (j == stall_row) begin
                m_if.ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    chk("stall_m_valid", int'(m_if.valid), 1);
                    chk("stall_m_data", int'($signed(m_if.data)), y[j]);
                    chk("stall_m_last", int'(m_if.last), 0);
                    chk("stall_s_ready", int'(s_if.ready), 0);
                end
                m_if.ready = 1'b1;
            end
        end
        @(negedge clk);
        chk("no_extra_output", int'(m_if.valid), 0);
        chk("s_ready_after_frame", int'(s_if.ready), 1);
    endtask

    task automatic check_reset_state();
        chk("rst_s_ready", int'(s_if.ready), 1);
        chk("rst_m_valid", int'(m_if.valid), 0);
        chk("rst_m_last", int'(m_if.last), 0);
        chk("rst_m_data", int'($signed(m_if.data)), 0);
`ifdef MATVEC_STREAM_LAST_CHECK_EN
        chk("rst_frame_err", int'(frame_err), 0);
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ones[R];
        int idy[R];
        int inc[C];

        vecs[0] = '{kmode: 1, kval: 0, x: '{1, 2, 3, 4, 5, 6, 7, 8},
                    y: '{1, 2, 3, 4, 5, 6, 7, 8}, gaps: 1'b0, stall_row: -1};
        vecs[1] = '{kmode: 0, kval: -128, x: '{default: -128},
                    y: '{default: 131072}, gaps: 1'b0, stall_row: -1};
        vecs[2] = '{kmode: 0, kval: -128, x: '{default: 127},
                    y: '{default: -130048}, gaps: 1'b0, stall_row: -1};
        vecs[3] = '{kmode: 1, kval: 0, x: '{1, 2, 3, 4, 5, 6, 7, 8},
                    y: '{1, 2, 3, 4, 5, 6, 7, 8}, gaps: 1'b1, stall_row: -1};
        vecs[4] = '{kmode: 1, kval: 0, x: '{1, 2, 3, 4, 5, 6, 7, 8},
                    y: '{1, 2, 3, 4, 5, 6, 7, 8}, gaps: 1'b0, stall_row: 3};
        vecs[5] = '{kmode: 0, kval: 2, x: '{127, -128, 127, -128, 127, -128, 127, -128},
                    y: '{default: -8}, gaps: 1'b0, stall_row: -1};
        vecs[6] = '{kmode: 1, kval: 0, x: '{-1, -2, -3, -4, -5, -6, -7, -8},
                    y: '{-1, -2, -3, -4, -5, -6, -7, -8}, gaps: 1'b0, stall_row: -1};

        rstn       = 1'b0;
        k          = '0;
        s_if.valid = 1'b0;
        s_if.data  = '0;
        s_if.last  = 1'b0;
        m_if.ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        check_reset_state();

        for (int n = 0; n < 7; n++) begin
            k = build_k(vecs[n].kmode, vecs[n].kval);
            send_frame(vecs[n].x, vecs[n].gaps, -1);
            recv_frame(vecs[n].y, vecs[n].stall_row);
        end
`ifdef MATVEC_STREAM_LAST_CHECK_EN
        chk("frame_err_clean_frames", int'(frame_err), 0);
`endif

        // Partial frame of 3 beats, then reset; the partial frame must vanish.
        k = build_k(0, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            s_if.valid = 1'b1;
            s_if.data  = 8'(10 * (i + 1));
            @(posedge clk);
        end
        @(negedge clk);
        s_if.valid = 1'b0;
        rstn       = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        check_reset_state();
        for (int i = 0; i < C; i++) inc[i] = i + 1;
        for (int r = 0; r < R; r++) ones[r] = 36;
        send_frame(inc, 1'b0, -1);
        recv_frame(ones, -1);

        // s_last asserted on beat 5: results unaffected, error flag sticky.
        k = build_k(1, 0);
        for (int r = 0; r < R; r++) idy[r] = r + 1;
        send_frame(inc, 1'b0, 4);
        recv_frame(idy, -1);
`ifdef MATVEC_STREAM_LAST_CHECK_EN
        chk("frame_err_sticky", int'(frame_err), 1);
        send_frame(inc, 1'b0, -1);
        recv_frame(idy, -1);
        chk("frame_err_sticky_next", int'(frame_err), 1);
        rstn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        chk("frame_err_cleared", int'(frame_err), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/matvec_stream_mac.md
Name: matvec_stream_mac

Overview:
- Streaming, time-multiplexed matrix-vector multiplier: y = K·x, K is R×C.
- Consumes the x vector one element per handshake beat on a valid/ready slave port.
- Accumulates all R row products in parallel using R multiply-accumulate units.
- Then emits y one row per beat on a valid/ready master port. Used where input and output are narrow streams rather than full parallel buses.

Parameters:
- R, 8, matrix rows = number of output elements per frame
- C, 8, matrix columns = number of input elements per frame
- W_X, 8, signed width of each x element
- W_K, 8, signed width of each k element
- W_Y, localparam = W_X + W_K + $clog2(C), signed width of each y element

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  synchronous active-low reset
- k  in  R*C*W_K  signed matrix, packed [R-1:0][C-1:0][W_K-1:0]; upstream holds it stable from first input beat to last output beat of a frame
- s_valid  in  1  x element valid
- s_ready  out  1  block accepts x element
- s_data  in  W_X  signed x element, column index = beat count
- s_last  in  1  upstream end-of-frame marker (see Optional Feature)
- m_valid  out  1  y element valid
- m_ready  in  1  downstream accepts y element
- m_data  out  W_Y  signed y element, row index = beat count
- m_last  out  1  high with final row (r = R-1)

Behaviour:
- Reset (rstn low at clk edge): state=ACC, col=0, row=0; s_ready=1 after reset; m_valid=0, m_last=0, m_data=0; accumulators=0. Reset mid-frame discards partial frame; no output produced for it.
- FSM states: ACC, OUT.
- ACC:
  - s_ready=1, m_valid=0.
  - On s_valid&s_ready, for every r in parallel: prod=k[r][col]*s_data (signed, W_X+W_K bits), sign-extended to W_Y.
  - col==0: acc[r]<=prod (implicit clear). Otherwise acc[r]<=acc[r]+prod.
  - col increments; on handshake with col==C-1: col<=0, row<=0, next state OUT.
- OUT:
  - s_ready=0, m_valid=1, m_data=acc[row], m_last=(row==R-1).
  - On m_valid&m_ready: row increments; if row==R-1, next state ACC.
- Latency: m_valid rises the cycle after the last input handshake. Full frame takes min C+R cycles.
- Throughput limit: no overlap of input and output phases; s_ready low for all of OUT.
- s_valid low in ACC: no state change. m_ready low in OUT: m_data/m_last held stable.
- Widths: W_Y guarantees no overflow for any signed inputs, including all operands at most-negative value.
- m_data is driven from registered acc via registered row index; no combinational path s_data→m_data.
- s_last is ignored unless the option below is compiled in.

Optional Feature:
- Macro: MATVEC_STREAM_LAST_CHECK_EN.
- Defined:
  - Adds output port frame_err (1 bit, reset 0, sticky until rstn).
  - Set when an accepted input beat has s_last != (col==C-1).
  - Frame processing is unaffected; counting stays C-beat based.
- Undefined: frame_err port absent, s_last unused, no check logic.

Test Plan (defaults R=8, C=8, W_X=W_K=8, W_Y=19):
- Identity K, x=1..8, s_valid always high, m_ready always high -> m_valid first high cycle after 8th input beat; m_data=1..8 on consecutive cycles; m_last only on value 8.
- All k=-128, x=-128 -> every y=131072. Then all k=-128, x=127 -> every y=-130048 (no wrap).
- Backpressure: m_ready low 5 cycles at row 3 -> m_data/m_last stable, s_ready=0 throughout; resumes with rows 3..7 intact.
- Input gaps: s_valid pseudo-random 50% duty with identity K, x=1..8 -> output identical to the first scenario.
- Reset mid-frame: rstn low 1 cycle after 3 input beats, then full frame K=all 1, x=1..8 -> every y=36, exactly 8 outputs, none from the partial frame.
- Macro defined: s_last high on beat 5 -> frame_err=1 cycle after, stays 1, y values still correct. Macro undefined: same stimulus -> normal output, no frame_err port.
